// File: rtl/flowing_lights_if.sv
// flowing_lights_if: LED bus under test plus checker status outputs
interface flowing_lights_if;
  logic [7:0] led_in;
  logic clr;
  logic locked;
  logic err;
  logic [1:0] err_code;
  logic [15:0] step_cnt;
  logic [7:0] lap_cnt;
  modport master (output led_in, clr, input locked, err, err_code, step_cnt, lap_cnt);
  modport slave (input led_in, clr, output locked, err, err_code, step_cnt, lap_cnt);
endinterface

// File: rtl/flowing_lights_checker.sv
// flowing_lights_checker: one-hot flowing-LED monitor; define LEDCHK_TIMING_EN for dwell/stall checks
module flowing_lights_checker #(
  parameter int PERIOD = 100000001,
  parameter int TOL = 2
) (
  input logic clk,
  input logic rst,
  flowing_lights_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SYNC, TRACK, ERROR} state_t;
  localparam logic [1:0] SEQ = 2'b01, TIMING = 2'b10, STALL = 2'b11;
  if (TOL < 0 || TOL >= PERIOD) begin : g_cfg
    $error("TOL must lie in [0, PERIOD)");
  end
  state_t state;
  logic [7:0] cur;
  logic [7:0] nxt;
  logic [1:0] code;
  logic [15:0] steps;
  logic [7:0] laps;
  assign nxt = cur[7] ? 8'h01 : {cur[6:0], 1'b0};
`ifdef LEDCHK_TIMING_EN
  localparam logic [31:0] MIN_D = 32'(PERIOD - TOL), MAX_D = 32'(PERIOD + TOL);
  logic [31:0] dwell;
  logic active, inc, load, stall, bad_dwell;
  assign active = !bus.clr && (state == SYNC || state == TRACK);
  assign inc = active && bus.led_in == cur && ~&dwell;
  assign load = !bus.clr && (state == IDLE ? bus.led_in == 8'h01 : active && bus.led_in == nxt);
  assign stall = dwell == MAX_D;
  assign bad_dwell = state == TRACK && (dwell < MIN_D || dwell > MAX_D);
  always_ff @(posedge clk)
    if (rst) dwell <= '0;
    else if (load) dwell <= 32'd1;
    else if (inc) dwell <= dwell + 32'd1;
`else
  localparam logic stall = 1'b0, bad_dwell = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cur <= '0;
      code <= '0;
      steps <= '0;
      laps <= '0;
    end else if (bus.clr) begin
      state <= IDLE;
      code <= '0;
      steps <= '0;
      laps <= '0;
    end else begin
      case (state)
        IDLE:
          if (bus.led_in == 8'h01) begin
            cur <= bus.led_in;
            state <= SYNC;
          end else if (bus.led_in != 8'h00) begin
            state <= ERROR;
            code <= SEQ;
          end
        SYNC, TRACK:
          if (bus.led_in == cur) begin
            if (stall) begin
              state <= ERROR;
              code <= STALL;
            end
          end else if (bus.led_in == 8'h00) state <= IDLE;
          else if (bus.led_in != nxt) begin
            state <= ERROR;
            code <= SEQ;
          end else if (bad_dwell) begin
            state <= ERROR;
            code <= TIMING;
          end else begin
            cur <= bus.led_in;
            state <= TRACK;
            steps <= steps + 16'd1;
            laps <= laps + 8'(cur[7]);
          end
        default: ;
      endcase
    end
  assign bus.locked = state == TRACK;
  assign bus.err = state == ERROR;
  assign bus.err_code = code;
  assign bus.step_cnt = steps;
  assign bus.lap_cnt = laps;
endmodule

// File: tb/tb_flowing_lights_checker.sv
// tb_flowing_lights_checker: directed plus random stimulus against a bit-position reference model
module tb_flowing_lights_checker;
  localparam int PERIOD = 10, TOL = 1;
`ifdef LEDCHK_TIMING_EN
  localparam bit TIMED = 1'b1;
`else
  localparam bit TIMED = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  flowing_lights_if bus();
  flowing_lights_checker #(.PERIOD(PERIOD), .TOL(TOL)) dut (.clk(clk), .rst(rst), .bus(bus));
  int total = 0;
  int bad = 0;
  // model: ph 0 idle, 1 sync, 2 track, 3 error; pos is the lit bit index, run its sample count
  int ph = 0, pos = -1, run = 0;
  logic [1:0] code = '0;
  logic [15:0] steps = '0;
  logic [7:0] laps = '0;
  function automatic int bit_pos(logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v == 8'(1 << i)) return i;
    return -1;
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model();
    int p = bit_pos(bus.led_in);
    if (rst) begin
      ph = 0; pos = -1; run = 0; code = 0; steps = 0; laps = 0;
    end else if (bus.clr) begin
      ph = 0; code = 0; steps = 0; laps = 0;
    end else if (ph == 0) begin
      if (p == 0) begin ph = 1; pos = 0; run = 1; end
      else if (bus.led_in != 0) begin ph = 3; code = 1; end
    end else if (ph != 3) begin
      if (p == pos) begin
        if (TIMED && run >= PERIOD + TOL) begin ph = 3; code = 3; end
        else run++;
      end else if (bus.led_in == 0) ph = 0;
      else if (p != (pos + 1) % 8) begin ph = 3; code = 1; end
      else if (TIMED && ph == 2 && (run < PERIOD - TOL || run > PERIOD + TOL)) begin ph = 3; code = 2; end
      else begin
        if (pos == 7) laps++;
        steps++;
        pos = p; run = 1; ph = 2;
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model();
    #1;
    chk("locked", 32'(bus.locked), 32'(ph == 2));
    chk("err", 32'(bus.err), 32'(ph == 3));
    chk("err_code", 32'(bus.err_code), 32'(code));
    chk("step_cnt", 32'(bus.step_cnt), 32'(steps));
    chk("lap_cnt", 32'(bus.lap_cnt), 32'(laps));
  endtask
  task automatic hold(logic [7:0] v, int n);
    bus.led_in = v;
    repeat (n) tick();
  endtask
  task automatic pulse_clr();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
  endtask
  initial begin
    logic [7:0] last;
    bus.led_in = 8'h00;
    bus.clr = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_locked", 32'(bus.locked), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_step", 32'(bus.step_cnt), 0);
    rst = 1'b0;
    hold(8'h00, 2);
    for (int i = 0; i < 8; i++) hold(8'(1 << i), 10);
    hold(8'h01, 1);
    chk("lap1_step", 32'(bus.step_cnt), 8);
    chk("lap1_lap", 32'(bus.lap_cnt), 1);
    chk("lap1_locked", 32'(bus.locked), 1);
    chk("lap1_err", 32'(bus.err), 0);
    hold(8'h01, 9);
    hold(8'h04, 1);
    chk("skip_code", 32'(bus.err_code), 1);
    chk("skip_locked", 32'(bus.locked), 0);
    hold(8'h08, 3);
    chk("skip_frozen", 32'(bus.step_cnt), 8);
    bus.led_in = 8'h00;
    pulse_clr();
    hold(8'h01, 10);
    hold(8'h02, 10);
    hold(8'h04, 8);
    hold(8'h08, 1);
    chk("short_code", 32'(bus.err_code), TIMED ? 2 : 0);
    bus.led_in = 8'h00;
    pulse_clr();
    hold(8'h01, 5);
    hold(8'h02, 9);
    hold(8'h04, 11);
    hold(8'h08, 10);
    chk("edge_err", 32'(bus.err), 0);
    hold(8'h10, 12);
    chk("stall_code", 32'(bus.err_code), TIMED ? 3 : 0);
    chk("stall_err", 32'(bus.err), 32'(TIMED));
    bus.led_in = 8'h00;
    pulse_clr();
    hold(8'h01, 10);
    hold(8'h02, 10);
    hold(8'h04, 10);
    hold(8'h00, 3);
    chk("stop_locked", 32'(bus.locked), 0);
    chk("stop_step", 32'(bus.step_cnt), 2);
    chk("stop_err", 32'(bus.err), 0);
    hold(8'h01, 10);
    hold(8'h02, 10);
    bus.led_in = 8'h08;
    pulse_clr();
    chk("clr_err", 32'(bus.err), 0);
    chk("clr_step", 32'(bus.step_cnt), 0);
    chk("clr_locked", 32'(bus.locked), 0);
    hold(8'h00, 1);
    for (int i = 0; i < 6; i++) hold(8'(1 << i), 10);
    chk("pre_rst_step", 32'(bus.step_cnt), 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_step", 32'(bus.step_cnt), 0);
    chk("mid_rst_locked", 32'(bus.locked), 0);
    hold(8'h01, 10);
    hold(8'h02, 10);
    chk("resync_locked", 32'(bus.locked), 1);
    chk("resync_err", 32'(bus.err), 0);
    last = 8'h02;
    for (int s = 0; s < 500; s++) begin
      int r = int'($urandom_range(0, 99));
      if (r < 70) begin
        last = last == 8'h00 ? 8'h01 : {last[6:0], last[7]};
        hold(last, r < 60 ? int'($urandom_range(9, 11)) : int'($urandom_range(7, 13)));
      end else if (r < 76) begin
        last = 8'($urandom);
        hold(last, int'($urandom_range(1, 3)));
      end else if (r < 82) begin
        last = 8'h00;
        hold(last, int'($urandom_range(1, 3)));
      end else if (r < 94) pulse_clr();
      else begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
